fft_frame_packer: RTL and testbench

Collects the serial bin stream from the FFT core and packs one complete 32-bin frame into the flat `fft_real`/`fft_imag` buses consumed by the spectrum display path, with a one-cycle `fft_done` strobe per frame. A shadow buffer keeps the output buses stable for the whole accumulation of the next frame. Malformed frames (bad SOP/EOP framing) are dropped and flagged. The display stage only ever sees complete frames.

---
 rtl/fft_frame_packer_pkg.sv | 21 ++
 rtl/fft_frame_packer_if.sv | 27 ++
 rtl/fft_frame_shadow.sv | 35 +++
 rtl/fft_frame_packer.sv | 133 +++++++++++++
 tb/tb_fft_frame_packer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_frame_packer_pkg.sv
// Shared definitions for the FFT frame packer and the display path that reads its buses.
// Frame geometry, the FSM state encoding and the bin-to-slice packing helper live here.
package fft_frame_packer_pkg;

  localparam int N_BINS = 32;
  localparam int DW     = 16;
  localparam int BW     = N_BINS * DW;
  localparam int IW     = $clog2(N_BINS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Bin k occupies [DW*k + DW-1 : DW*k] of a packed bus.
  function automatic int unsigned slice_lo(input int unsigned k);
    return k * DW;
  endfunction

endpackage

// File: rtl/fft_frame_packer_if.sv
// Bin-stream input and packed-frame output signals of the packer.
// The master side is the FFT core / display pair, the slave side is the packer.
interface fft_frame_packer_if;
  import fft_frame_packer_pkg::*;

  logic          bin_valid;
  logic          bin_sop;
  logic          bin_eop;
  logic [DW-1:0] bin_real;
  logic [DW-1:0] bin_imag;
  logic [BW-1:0] fft_real;
  logic [BW-1:0] fft_imag;
  logic          fft_done;
  logic          frame_err;
  logic          busy;

  modport master (
    output bin_valid, bin_sop, bin_eop, bin_real, bin_imag,
    input  fft_real, fft_imag, fft_done, frame_err, busy
  );

  modport slave (
    input  bin_valid, bin_sop, bin_eop, bin_real, bin_imag,
    output fft_real, fft_imag, fft_done, frame_err, busy
  );

endinterface

// File: rtl/fft_frame_shadow.sv
// Shadow register file: one {imag, real} word per bin with an indexed write port
// and a full-width parallel read of the packed real and imaginary buses.
module fft_frame_shadow
  import fft_frame_packer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [2*DW-1:0] wr_data,
  output logic [BW-1:0]   rd_real,
  output logic [BW-1:0]   rd_imag
);

  logic [2*DW-1:0] word_reg [N_BINS];

  // Every word is read in parallel, so storage stays in flops rather than RAM.
  generate
    for (genvar gi = 0; gi < N_BINS; gi++) begin : g_word
      localparam logic [IW-1:0] IDX = IW'(gi);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == IDX)) begin
          word_reg[gi] <= wr_data;
        end
      end

      assign rd_real[slice_lo(gi) +: DW] = word_reg[gi][DW-1:0];
      assign rd_imag[slice_lo(gi) +: DW] = word_reg[gi][2*DW-1:DW];
    end
  endgenerate

endmodule

// File: rtl/fft_frame_packer.sv
// Packs one complete 32-bin FFT frame from the serial bin stream onto flat buses,
// dropping and flagging frames with bad SOP/EOP framing.
module fft_frame_packer
  import fft_frame_packer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fft_frame_packer_if.slave bus
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_BINS - 1);

  state_t          state_reg;
  logic [IW-1:0]   bin_idx_reg;
  logic [BW-1:0]   fft_real_reg;
  logic [BW-1:0]   fft_imag_reg;
  logic            fft_done_reg;
  logic            frame_err_reg;
  logic            busy_reg;

  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [2*DW-1:0] wr_data;
  logic [BW-1:0]   shadow_real;
  logic [BW-1:0]   shadow_imag;

  wire sop_hit = bus.bin_valid && bus.bin_sop;

  // Shadow write decode; it must see the same decisions the FSM makes below.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = bin_idx_reg;
    wr_data = {bus.bin_imag, bus.bin_real};
    case (state_reg)
      ST_COLLECT: begin
        if (bus.bin_valid) begin
          if (bus.bin_sop) begin
            wr_en  = 1'b1;
            wr_idx = '0;
          end else if (bin_idx_reg == LAST_IDX) begin
            wr_en = bus.bin_eop;
          end else begin
            wr_en = !bus.bin_eop;
          end
        end
      end
      default: begin
        if (sop_hit) begin
          wr_en  = 1'b1;
          wr_idx = '0;
        end
      end
    endcase
  end

  fft_frame_shadow u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_real (shadow_real),
    .rd_imag (shadow_imag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bin_idx_reg   <= '0;
      fft_real_reg  <= '0;
      fft_imag_reg  <= '0;
      fft_done_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      fft_done_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_COLLECT: begin
          if (bus.bin_valid) begin
            if (bus.bin_sop) begin
              bin_idx_reg   <= IW'(1);
              frame_err_reg <= 1'b1;
            end else if (bin_idx_reg != LAST_IDX) begin
              if (bus.bin_eop) begin
                bin_idx_reg   <= '0;
                frame_err_reg <= 1'b1;
                state_reg     <= ST_IDLE;
                busy_reg      <= 1'b0;
              end else begin
                bin_idx_reg <= bin_idx_reg + IW'(1);
              end
            end else begin
              // Bin 31: EOP commits, anything else is a missing-EOP drop.
              bin_idx_reg   <= '0;
              frame_err_reg <= !bus.bin_eop;
              state_reg     <= bus.bin_eop ? ST_COMMIT : ST_IDLE;
              busy_reg      <= 1'b0;
            end
          end
        end
        ST_COMMIT: begin
          fft_real_reg <= shadow_real;
          fft_imag_reg <= shadow_imag;
          fft_done_reg <= 1'b1;
          if (sop_hit) begin
            bin_idx_reg <= IW'(1);
            state_reg   <= ST_COLLECT;
            busy_reg    <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          if (sop_hit) begin
            bin_idx_reg <= IW'(1);
            state_reg   <= ST_COLLECT;
            busy_reg    <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.fft_real  = fft_real_reg;
  assign bus.fft_imag  = fft_imag_reg;
  assign bus.fft_done  = fft_done_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Scoreboard bench for fft_frame_packer: expected frames are queued as they are
// sent and compared when fft_done is observed.
module tb_fft_frame_packer;
  import fft_frame_packer_pkg::*;

  typedef struct {
    logic [BW-1:0] re;
    logic [BW-1:0] im;
  } frame_t;

  logic clk;
  logic rst_n;
  fft_frame_packer_if ifc ();

  fft_frame_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;
  frame_t sb_q[$];
  logic [DW-1:0] frame_re [N_BINS];
  logic [DW-1:0] frame_im [N_BINS];
  logic [BW-1:0] last_re;
  logic [BW-1:0] last_im;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    frame_t e;
    if (rst_n) begin
      if (ifc.frame_err) err_cnt++;
      if (ifc.fft_done) begin
        done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        $display("frame %0d committed at cycle %0d", done_cnt, cyc);
        if (sb_q.size() == 0) begin
          check_eq("done_unexpected", BW'(1), BW'(0));
        end else begin
          e = sb_q.pop_front();
          check_eq("fft_real", ifc.fft_real, e.re);
          check_eq("fft_imag", ifc.fft_imag, e.im);
        end
      end
    end
  end

  task automatic send_bin(input logic v, input logic s, input logic e,
                          input logic [DW-1:0] re, input logic [DW-1:0] im);
    ifc.bin_valid = v;
    ifc.bin_sop   = s;
    ifc.bin_eop   = e;
    ifc.bin_real  = re;
    ifc.bin_imag  = im;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bin(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic fill_ramp(input int mul);
    for (int k = 0; k < N_BINS; k++) begin
      frame_re[k] = DW'(k * mul);
      frame_im[k] = DW'(0) - DW'(k * mul);
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int k = 0; k < N_BINS; k++) begin
      frame_re[k] = v;
      frame_im[k] = v;
    end
  endtask

  // Sends bins 0..31 from frame_re/im; a good frame is queued as expected output.
  task automatic send_frame(input bit gap, input bit good);
    frame_t f;
    for (int k = 0; k < N_BINS; k++) begin
      f.re[k*DW +: DW] = frame_re[k];
      f.im[k*DW +: DW] = frame_im[k];
      send_bin(1'b1, k == 0, good && (k == N_BINS - 1), frame_re[k], frame_im[k]);
      if (k == 0) check_eq("busy_after_sop", BW'(ifc.busy), BW'(1));
      if (gap && k != N_BINS - 1) idle(1);
    end
    if (good) begin
      sb_q.push_back(f);
      last_re = f.re;
      last_im = f.im;
    end
  endtask

  initial begin
    int exp_err;
    int exp_done;
    exp_err  = 0;
    exp_done = 0;
    ifc.bin_valid = 1'b0;
    ifc.bin_sop   = 1'b0;
    ifc.bin_eop   = 1'b0;
    ifc.bin_real  = '0;
    ifc.bin_imag  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_fft_real", ifc.fft_real, BW'(0));
    check_eq("rst_fft_imag", ifc.fft_imag, BW'(0));
    check_eq("rst_done_err_busy", BW'({ifc.fft_done, ifc.frame_err, ifc.busy}), BW'(0));
    rst_n = 1'b1;
    idle(2);

    // Stray bins without SOP in IDLE are ignored silently.
    for (int i = 0; i < 4; i++) send_bin(1'b1, 1'b0, i == 3, DW'(i), DW'(i));
    idle(2);
    check_eq("idle_stray_err", BW'(err_cnt), BW'(exp_err));
    check_eq("idle_stray_busy", BW'(ifc.busy), BW'(0));

    // Clean frame with latency check.
    fill_ramp(1);
    send_frame(1'b0, 1'b1);
    exp_done++;
    check_eq("done_at_eop_edge", BW'(ifc.fft_done), BW'(0));
    idle(1);
    check_eq("done_rise", BW'(ifc.fft_done), BW'(1));
    check_eq("busy_in_commit", BW'(ifc.busy), BW'(0));
    idle(1);
    check_eq("done_fall", BW'(ifc.fft_done), BW'(0));
    idle(2);

    // Gapped frame, same data.
    send_frame(1'b1, 1'b1);
    exp_done++;
    idle(3);
    check_eq("gap_done_cnt", BW'(done_cnt), BW'(exp_done));

    // Early EOP on bin 10: dropped, buses hold the previous frame.
    for (int k = 0; k <= 10; k++) send_bin(1'b1, k == 0, k == 10, 16'hAAAA, 16'hAAAA);
    exp_err++;
    idle(3);
    check_eq("early_eop_err", BW'(err_cnt), BW'(exp_err));
    check_eq("early_eop_hold_re", ifc.fft_real, last_re);
    check_eq("early_eop_hold_im", ifc.fft_imag, last_im);
    fill_ramp(3);
    send_frame(1'b0, 1'b1);
    exp_done++;
    idle(3);

    // Missing EOP on bin 31: dropped.
    fill_const(16'h5555);
    send_frame(1'b0, 1'b0);
    exp_err++;
    idle(3);
    check_eq("missing_eop_err", BW'(err_cnt), BW'(exp_err));
    check_eq("missing_eop_hold", ifc.fft_real, last_re);

    // SOP at bin 20 restarts onto a full 0x7FFF frame.
    for (int k = 0; k < 20; k++) send_bin(1'b1, k == 0, 1'b0, DW'(k), DW'(k));
    fill_const(16'h7FFF);
    send_frame(1'b0, 1'b1);
    exp_err++;
    exp_done++;
    idle(3);
    check_eq("restart_err", BW'(err_cnt), BW'(exp_err));

    // Back-to-back A and B; B's SOP lands in A's COMMIT cycle.
    fill_const(16'h1111);
    send_frame(1'b0, 1'b1);
    fill_const(16'h2222);
    send_frame(1'b0, 1'b1);
    exp_done += 2;
    idle(3);
    check_eq("b2b_spacing", BW'(last_done_cyc - prev_done_cyc), BW'(32));
    check_eq("b2b_err", BW'(err_cnt), BW'(exp_err));

    // Reset at bin 15 drops the partial frame.
    fill_ramp(5);
    for (int k = 0; k < 15; k++) send_bin(1'b1, k == 0, 1'b0, frame_re[k], frame_im[k]);
    ifc.bin_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_fft_real", ifc.fft_real, BW'(0));
    check_eq("midrst_fft_imag", ifc.fft_imag, BW'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("midrst_outputs", BW'({ifc.fft_done, ifc.frame_err, ifc.busy}), BW'(0));
    end
    rst_n = 1'b1;
    idle(2);
    fill_ramp(7);
    send_frame(1'b0, 1'b1);
    exp_done++;
    idle(3);

    check_eq("total_done", BW'(done_cnt), BW'(exp_done));
    check_eq("total_err", BW'(err_cnt), BW'(exp_err));
    check_eq("sb_empty", BW'(sb_q.size()), BW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
